// File: rtl/arm_pipe_pkg.sv
// Shared definitions for the ARMv8 pipeline stages.
//   INSTR_W / ADDR_W : instruction and address widths
//   NOP_INSTR        : encoding used to fill a pipeline bubble
//   if_id_t          : IF/ID bundle {instruction, pc, pc_inc, valid}
//   pc_plus4         : modulo-2^64 sequential PC increment
package arm_pipe_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F;

  typedef struct packed {
    logic [INSTR_W-1:0] instruction;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_inc;
    logic               valid;
  } if_id_t;

  // Wraps naturally: FFFF_FFFF_FFFF_FFFC + 4 = 0.
  function automatic logic [ADDR_W-1:0] pc_plus4(input logic [ADDR_W-1:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/if_id_register.sv
// Generic pipeline register carrying an if_id_t bundle.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-low; clears the bundle to a bubble with zero PCs
//   load   : capture d
//   hold   : keep current contents (overrides load)
//   bubble : replace instruction with NOP and clear valid, PCs keep their value
//            (overrides hold and load)
//   d / q  : bundle in / out
module if_id_register
  import arm_pipe_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP = NOP_INSTR
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   load,
  input  logic   hold,
  input  logic   bubble,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clock) begin
    if (!reset) begin
      q.instruction <= NOP;
      q.pc          <= '0;
      q.pc_inc      <= '0;
      q.valid       <= 1'b0;
    end else if (bubble) begin
      // PCs are left alone so a bubble never disturbs link/debug values.
      q.instruction <= NOP;
      q.valid       <= 1'b0;
    end else if (load && !hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory and drives
// the IF/ID pipeline register feeding instruction_decode.
// Parameters:
//   RESET_PC  : PC loaded on reset
//   NOP_INSTR : encoding placed in IF/ID for a bubble
// Ports:
//   clock, reset (sync, active-low)
//   stall              : hold PC and IF/ID
//   branch_taken       : redirect from ID, target in branch_target (aligned to 4)
//   imem_rdata/valid   : combinational instruction memory response for imem_addr
//   imem_addr          : current PC
//   instruction_IF_ID, PC_out_IF_ID, PC_inc_IF_ID, valid_IF_ID : IF/ID outputs
// Optional feature macro IF_PERF_CNT_EN adds saturating fetch_count and
// bubble_count outputs.
// Priority each cycle: reset > branch > stall > memory not ready > fetch.
module instruction_fetch
  import arm_pipe_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = 64'h0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = arm_pipe_pkg::NOP_INSTR
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] instruction_IF_ID,
  output logic [ADDR_W-1:0]  PC_out_IF_ID,
  output logic [ADDR_W-1:0]  PC_inc_IF_ID,
  output logic               valid_IF_ID
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        bubble_count
`endif
);

  // ---- stage p0: PC and fetch request ----
  logic [ADDR_W-1:0] pc_p0;
  logic [ADDR_W-1:0] pc_inc_p0;
  logic              do_fetch_p0;
  logic              do_bubble_p0;
  if_id_t            fetch_p0;
  if_id_t            if_id_p1;

  assign pc_inc_p0 = pc_plus4(pc_p0);
  assign imem_addr = pc_p0;

  // Branch beats stall; stall beats a not-ready memory (no bubble while stalled).
  assign do_fetch_p0  = !branch_taken && !stall && imem_valid;
  assign do_bubble_p0 = branch_taken || (!stall && !imem_valid);

  assign fetch_p0.instruction = imem_rdata;
  assign fetch_p0.pc          = pc_p0;
  assign fetch_p0.pc_inc      = pc_inc_p0;
  assign fetch_p0.valid       = 1'b1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_p0 <= RESET_PC;
    end else if (branch_taken) begin
      pc_p0 <= {branch_target[ADDR_W-1:2], 2'b00};
    end else if (do_fetch_p0) begin
      pc_p0 <= pc_inc_p0;
    end
  end

  // ---- stage p1: IF/ID register ----
  if_id_register #(
    .NOP (NOP_INSTR)
  ) u_if_id (
    .clock  (clock),
    .reset  (reset),
    .load   (do_fetch_p0),
    .hold   (stall),
    .bubble (do_bubble_p0),
    .d      (fetch_p0),
    .q      (if_id_p1)
  );

  assign instruction_IF_ID = if_id_p1.instruction;
  assign PC_out_IF_ID      = if_id_p1.pc;
  assign PC_inc_IF_ID      = if_id_p1.pc_inc;
  assign valid_IF_ID       = if_id_p1.valid;

`ifdef IF_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clock) begin
    if (!reset) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (do_fetch_p0)  fetch_count  <= sat_inc(fetch_count);
      if (do_bubble_p0) bubble_count <= sat_inc(bubble_count);
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic [31:0] imem_rdata;
  logic        imem_valid = 1'b1;
  logic [63:0] imem_addr;
  logic [31:0] instruction_IF_ID;
  logic [63:0] PC_out_IF_ID;
  logic [63:0] PC_inc_IF_ID;
  logic        valid_IF_ID;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  localparam logic [31:0] NOP = 32'hD503201F;

  instruction_fetch dut (
    .clock             (clock),
    .reset             (reset),
    .stall             (stall),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .imem_rdata        (imem_rdata),
    .imem_valid        (imem_valid),
    .imem_addr         (imem_addr),
    .instruction_IF_ID (instruction_IF_ID),
    .PC_out_IF_ID      (PC_out_IF_ID),
    .PC_inc_IF_ID      (PC_inc_IF_ID),
    .valid_IF_ID       (valid_IF_ID)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count       (fetch_count),
    .bubble_count      (bubble_count)
`endif
  );

  always #5 clock = ~clock;

  // Instruction memory contents: constant word, or an address hash.
  logic mem_const = 1'b1;
  function automatic logic [31:0] mem_word(input logic c, input logic [63:0] a);
    return c ? 32'h8B020020 : ((a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A0F0F);
  endfunction
  always_comb imem_rdata = mem_word(mem_const, imem_addr);

  typedef struct {
    logic [63:0] addr;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] inc;
    logic        valid;
    logic [31:0] fc;
    logic [31:0] bc;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Reference state: what the fetch stage should hold after each edge.
  logic [63:0] m_pc = '0;
  exp_t        m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  // Drive one cycle of inputs and predict the state after the next rising edge.
  task automatic step(input logic rst_n, input logic br, input logic [63:0] tgt,
                      input logic st, input logic iv);
    @(negedge clock);
    reset = rst_n; branch_taken = br; branch_target = tgt; stall = st; imem_valid = iv;
    if (!rst_n) begin
      m_pc = 64'h0;
      m.instr = NOP; m.pc = '0; m.inc = '0; m.valid = 1'b0; m.fc = '0; m.bc = '0;
    end else if (br) begin
      m_pc = tgt & ~64'h3;
      m.instr = NOP; m.valid = 1'b0; m.bc = sat1(m.bc);
    end else if (st) begin
      // everything holds
    end else if (!iv) begin
      m.instr = NOP; m.valid = 1'b0; m.bc = sat1(m.bc);
    end else begin
      m.instr = mem_word(mem_const, m_pc);
      m.pc = m_pc; m.inc = m_pc + 64'd4; m.valid = 1'b1; m.fc = sat1(m.fc);
      m_pc = m_pc + 64'd4;
    end
    m.addr = m_pc;
    exp_q.push_back(m);
  endtask

  // Monitor: the DUT presents a new IF/ID state every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_addr", imem_addr, e.addr);
        chk("instruction_IF_ID", {32'h0, instruction_IF_ID}, {32'h0, e.instr});
        chk("PC_out_IF_ID", PC_out_IF_ID, e.pc);
        chk("PC_inc_IF_ID", PC_inc_IF_ID, e.inc);
        chk("valid_IF_ID", {63'h0, valid_IF_ID}, {63'h0, e.valid});
`ifdef IF_PERF_CNT_EN
        chk("fetch_count", {32'h0, fetch_count}, {32'h0, e.fc});
        chk("bubble_count", {32'h0, bubble_count}, {32'h0, e.bc});
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (actual running, required done)");
    $fatal(1, "timeout");
  end

  initial begin
    m.addr = '0; m.instr = NOP; m.pc = '0; m.inc = '0; m.valid = 1'b0; m.fc = '0; m.bc = '0;

    // Reset, then stream from 0 with a constant memory word.
    step(0, 0, 64'h0, 0, 1);
    step(0, 0, 64'h0, 0, 1);
    step(1, 0, 64'h0, 0, 1);
    step(1, 0, 64'h0, 0, 1);
    // Stall three cycles at PC 8, then resume.
    repeat (3) step(1, 0, 64'h0, 1, 1);
    step(1, 0, 64'h0, 0, 1);
    // Misaligned branch at PC 12 lands on 0x100.
    step(1, 1, 64'h103, 0, 1);
    step(1, 0, 64'h0, 0, 1);
    // Memory not ready twice, then fetch.
    step(1, 0, 64'h0, 0, 0);
    step(1, 0, 64'h0, 0, 0);
    step(1, 0, 64'h0, 0, 1);
    // Branch together with stall: branch wins.
    step(1, 1, 64'h2000, 1, 1);
    step(1, 0, 64'h0, 0, 1);
    // Stall with memory not ready: no bubble.
    step(1, 0, 64'h0, 1, 0);
    // Wrap at the top of the address space.
    mem_const = 1'b0;
    step(1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
    step(1, 0, 64'h0, 0, 1);
    step(1, 0, 64'h0, 0, 1);
    // Reset wins over stall and over a redirect.
    step(1, 0, 64'h0, 1, 1);
    step(0, 0, 64'h0, 1, 1);
    step(1, 0, 64'h0, 0, 1);
    step(0, 1, 64'h4444, 0, 1);
    step(1, 0, 64'h0, 0, 1);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 50) != 0, ($urandom % 10) == 0, {$urandom, $urandom},
           ($urandom % 5) == 0, ($urandom % 4) != 0);
    end
    @(posedge clock);
    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
